// File: rtl/anti_theft_if.sv
// anti_theft_if
//   Groups the debounced control inputs and the status outputs of the
//   anti-theft controller. All signals are plain clock-synchronous levels;
//   there is no valid/ready handshake, every input is sampled at each
//   rising clock edge and every output changes only on that edge.
//   master : drives the inputs, observes the outputs (vehicle side / bench)
//   slave  : the controller itself
// Signals:
//   ignition, driver_door, passenger_door, hidden_switch, brake_pedal,
//   reprogram                 - debounced input levels (1 = active / open)
//   siren, status_led, fuel_pump - controller outputs
//   state_out [2:0]           - current FSM state encoding
//   time_left [3:0]           - remaining countdown seconds
interface anti_theft_if;
   logic       ignition;
   logic       driver_door;
   logic       passenger_door;
   logic       hidden_switch;
   logic       brake_pedal;
   logic       reprogram;
   logic       siren;
   logic       status_led;
   logic       fuel_pump;
   logic [2:0] state_out;
   logic [3:0] time_left;

   modport master (
      output ignition, driver_door, passenger_door, hidden_switch,
             brake_pedal, reprogram,
      input  siren, status_led, fuel_pump, state_out, time_left
   );

   modport slave (
      input  ignition, driver_door, passenger_door, hidden_switch,
             brake_pedal, reprogram,
      output siren, status_led, fuel_pump, state_out, time_left
   );
endinterface

// File: rtl/anti_theft_fsm.sv
// anti_theft_fsm
//   Central anti-theft controller: sequences arm / trigger / alarm / disarm
//   with second-resolution countdowns and drives siren, status LED and the
//   fuel-pump enable. All outputs are registered.
// Ports:
//   clock_in - system clock
//   reset_in - asynchronous, active-high reset
//   bus      - anti_theft_if.slave (inputs and status outputs)
// Parameters:
//   ONE_HZ_TICKS - clock cycles per second tick (>= 2)
//   T_ARM, T_DRIVER, T_PASSENGER, T_ALARM_ON - delays in seconds (1..15)
module anti_theft_fsm #(
   parameter int ONE_HZ_TICKS = 27_000_000,
   parameter int T_ARM        = 6,
   parameter int T_DRIVER     = 8,
   parameter int T_PASSENGER  = 15,
   parameter int T_ALARM_ON   = 10
) (
   input logic         clock_in,
   input logic         reset_in,
   anti_theft_if.slave bus
);

   typedef enum logic [2:0] {
      ARMED           = 3'd0,
      TRIGGERED       = 3'd1,
      SOUND_ALARM     = 3'd2,
      ALARM_HOLD      = 3'd3,
      DISARMED        = 3'd4,
      WAIT_DOOR_OPEN  = 3'd5,
      WAIT_DOOR_CLOSE = 3'd6,
      ARM_DELAY       = 3'd7
   } state_t;

   localparam int            PW        = $clog2(ONE_HZ_TICKS);
   localparam logic [PW-1:0] PRESC_MAX = PW'(ONE_HZ_TICKS - 1);

   state_t        state, state_n;
   logic [3:0]    cnt, cnt_n;
   logic [PW-1:0] presc;
   logic          presc_clr;
   logic          led, led_n;
   logic          siren_r, siren_n;
   logic          pump, pump_n;
   logic          sec_tick;
   logic          expiry;
   logic          door_open;

   assign sec_tick  = (presc == PRESC_MAX);
   // The last tick of a countdown is the expiry edge; the count reads 0 after it.
   assign expiry    = sec_tick && (cnt == 4'd1);
   assign door_open = bus.driver_door || bus.passenger_door;

   always_comb begin
      state_n   = state;
      cnt_n     = cnt;
      presc_clr = 1'b0;
      led_n     = 1'b0;
      siren_n   = 1'b0;
      pump_n    = pump;

      if (sec_tick && cnt != 4'd0) cnt_n = cnt - 4'd1;

      if (bus.reprogram) begin
         state_n   = ARMED;
         cnt_n     = 4'd0;
         presc_clr = 1'b1;
      end else begin
         case (state)
            ARMED: begin
               if (bus.ignition) state_n = DISARMED;
               else if (bus.driver_door) begin
                  // Driver delay also wins when both doors open together.
                  state_n   = TRIGGERED;
                  cnt_n     = 4'(T_DRIVER);
                  presc_clr = 1'b1;
               end else if (bus.passenger_door) begin
                  state_n   = TRIGGERED;
                  cnt_n     = 4'(T_PASSENGER);
                  presc_clr = 1'b1;
               end
            end
            TRIGGERED: begin
               if (bus.ignition) state_n = DISARMED;
               else if (expiry)  state_n = SOUND_ALARM;
            end
            SOUND_ALARM: begin
               if (bus.ignition) state_n = DISARMED;
               else if (!door_open) begin
                  state_n   = ALARM_HOLD;
                  cnt_n     = 4'(T_ALARM_ON);
                  presc_clr = 1'b1;
               end
            end
            ALARM_HOLD: begin
               if (bus.ignition)  state_n = DISARMED;
               else if (door_open) state_n = SOUND_ALARM;
               else if (expiry)    state_n = ARMED;
            end
            DISARMED: begin
               if (!bus.ignition) state_n = WAIT_DOOR_OPEN;
            end
            WAIT_DOOR_OPEN: begin
               if (bus.ignition)         state_n = DISARMED;
               else if (bus.driver_door) state_n = WAIT_DOOR_CLOSE;
            end
            WAIT_DOOR_CLOSE: begin
               if (bus.ignition) state_n = DISARMED;
               else if (!bus.driver_door) begin
                  state_n   = ARM_DELAY;
                  cnt_n     = 4'(T_ARM);
                  presc_clr = 1'b1;
               end
            end
            ARM_DELAY: begin
               if (bus.ignition)   state_n = DISARMED;
               else if (door_open) state_n = WAIT_DOOR_CLOSE;
               else if (expiry)    state_n = ARMED;
            end
            default: state_n = ARMED;
         endcase
      end

      // The count is only meaningful in the timed states; elsewhere it reads 0
      // and a remaining count is discarded when a timed state is left.
      if (!(state_n == TRIGGERED || state_n == ALARM_HOLD || state_n == ARM_DELAY))
         cnt_n = 4'd0;

      siren_n = (state_n == SOUND_ALARM) || (state_n == ALARM_HOLD);

      case (state_n)
         TRIGGERED, SOUND_ALARM, ALARM_HOLD: led_n = 1'b1;
         // Blink while armed: cleared on entry (or re-arm), toggled each second.
         ARMED: led_n = (state == ARMED && !bus.reprogram) ? (led ^ sec_tick) : 1'b0;
         default: led_n = 1'b0;
      endcase

      // Pump: switched on only from DISARMED with the full secret combination,
      // dropped as soon as ignition goes away or the disarmed group is left.
      if (bus.reprogram || !bus.ignition || !state_n[2])
         pump_n = 1'b0;
      else if (!pump && state == DISARMED && bus.ignition &&
               bus.hidden_switch && bus.brake_pedal)
         pump_n = 1'b1;
   end

   always_ff @(posedge clock_in or posedge reset_in) begin
      if (reset_in) begin
         state   <= ARMED;
         cnt     <= 4'd0;
         presc   <= '0;
         led     <= 1'b0;
         siren_r <= 1'b0;
         pump    <= 1'b0;
      end else begin
         state   <= state_n;
         cnt     <= cnt_n;
         presc   <= (presc_clr || sec_tick) ? '0 : presc + 1'b1;
         led     <= led_n;
         siren_r <= siren_n;
         pump    <= pump_n;
      end
   end

   assign bus.state_out  = state;
   assign bus.time_left  = cnt;
   assign bus.siren      = siren_r;
   assign bus.status_led = led;
   assign bus.fuel_pump  = pump;

endmodule

// File: doc/anti_theft_fsm.md
# anti_theft_fsm

Central controller of the anti-theft system, directly downstream of the per-input debouncers. It consumes clean, clock-synchronous levels for ignition, doors, hidden switch, brake pedal and reprogram. It sequences arm / trigger / alarm / disarm with second-resolution countdowns, and drives the siren, status LED and fuel-pump enable.

## Interface
- ONE_HZ_TICKS, 27_000_000, clock cycles per second tick (≥2; benches use 4)
- T_ARM, 6, arm delay in seconds (1..15)
- T_DRIVER, 8, entry delay after driver door (1..15)
- T_PASSENGER, 15, entry delay after passenger door (1..15)
- T_ALARM_ON, 10, siren hold time after all doors closed (1..15)

Ports:
- clock_in  in  1  system clock
- reset_in  in  1  asynchronous, active-high reset
- ignition  in  1  debounced ignition level
- driver_door  in  1  debounced, 1 = open
- passenger_door  in  1  debounced, 1 = open
- hidden_switch  in  1  debounced hidden switch
- brake_pedal  in  1  debounced, 1 = pressed
- reprogram  in  1  debounced, forces re-arm
- siren  out  1  alarm output
- status_led  out  1  dashboard LED
- fuel_pump  out  1  fuel-pump power enable
- state_out  out  3  current state encoding
- time_left  out  4  remaining countdown seconds (0 when idle)

## Operation
- Encoding: ARMED=0, TRIGGERED=1, SOUND_ALARM=2, ALARM_HOLD=3, DISARMED=4, WAIT_DOOR_OPEN=5, WAIT_DOOR_CLOSE=6, ARM_DELAY=7.
- Priority within a state: reprogram > ignition > door conditions > countdown expiry.
- Any state, reprogram=1 → ARMED. Clears the countdown and prescaler.
- ARMED:
  - ignition → DISARMED.
  - Else driver_door → TRIGGERED, load T_DRIVER.
  - Else passenger_door → TRIGGERED, load T_PASSENGER.
  - Both doors open: driver delay wins.
- TRIGGERED: ignition → DISARMED; expiry → SOUND_ALARM.
- SOUND_ALARM:
  - ignition → DISARMED.
  - Both doors closed → ALARM_HOLD, load T_ALARM_ON.
- ALARM_HOLD:
  - ignition → DISARMED.
  - Any door open → SOUND_ALARM.
  - Expiry → ARMED.
- DISARMED: ignition=0 → WAIT_DOOR_OPEN.
- WAIT_DOOR_OPEN: ignition → DISARMED; driver_door → WAIT_DOOR_CLOSE.
- WAIT_DOOR_CLOSE: ignition → DISARMED; driver_door=0 → ARM_DELAY, load T_ARM.
- ARM_DELAY:
  - ignition → DISARMED.
  - Any door open → WAIT_DOOR_CLOSE.
  - Expiry → ARMED.
- Outputs:
  - siren=1 only in SOUND_ALARM and ALARM_HOLD.
  - status_led=1 in TRIGGERED, SOUND_ALARM and ALARM_HOLD.
  - status_led=0 in states 4–7.
  - In ARMED, status_led is cleared on entry and toggles on every second tick.
- Fuel pump, separate 2-state machine:
  - OFF → ON when ignition & hidden_switch & brake_pedal are all 1 in the same cycle while state_out=DISARMED.
  - ON → OFF whenever ignition=0, on reprogram, or on leaving states 4–7.
  - fuel_pump is the ON indication.
- time_left shows the countdown value in TRIGGERED, ALARM_HOLD and ARM_DELAY; 0 elsewhere.

## Timing
- Reset (asynchronous):
  - state=ARMED; countdown=0; prescaler=0.
  - siren=0, status_led=0, fuel_pump=0, state_out=0, time_left=0.
- All outputs are registered; each reflects a transition on the same edge as the state register.
- Prescaler:
  - Counts 0..ONE_HZ_TICKS-1, pulsing sec_tick for one cycle at terminal count.
  - Free-running in ARMED.
  - Zeroed on every countdown load.
- Countdown:
  - A load of N at edge E gives time_left=N.
  - Decrements on each sec_tick.
  - Expiry transition occurs at edge E + N·ONE_HZ_TICKS, with time_left=0.
- Re-entering SOUND_ALARM from ALARM_HOLD discards the remaining count; the next closure reloads T_ALARM_ON in full.
- Input changes take effect at the first clock edge after they are sampled; no edge detection, level semantics only.
- Reset asserted mid-countdown: immediate return to reset values; no tick carry-over after release.

## Test plan
- Reset, ONE_HZ_TICKS=4, driver_door=1 for one cycle:
  - TRIGGERED with time_left=8.
  - SOUND_ALARM and siren=1 exactly 32 cycles after the load.
- Alarm hold:
  - In SOUND_ALARM, close both doors → ALARM_HOLD with time_left=10.
  - Reopen the passenger door at time_left=3 → SOUND_ALARM.
  - Close again → time_left=10.
  - Expiry → ARMED, siren=0.
- Disarm and re-arm:
  - ignition=1 in TRIGGERED → DISARMED, status_led=0.
  - ignition=0 → state 5.
  - Driver door open → state 6; close → ARM_DELAY, time_left=6.
  - ARMED after 24 cycles; status_led toggles every 4 cycles.
- Fuel pump enable:
  - In DISARMED, hidden_switch=1, brake_pedal=0 → fuel_pump stays 0.
  - Both 1 → fuel_pump=1 next edge.
  - Drop ignition → fuel_pump=0 and state 5.
- Simultaneous events:
  - Both doors opening in ARMED → time_left=8.
  - reprogram=1 with ignition=1 in ARM_DELAY → ARMED.
- Asynchronous reset:
  - Assert reset_in between clock edges while in ARM_DELAY → state_out=0 and all outputs 0 before the next edge.
